// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: icache request/response, decode-side control and IF/ID latch.
// The master side is the fetch stage; the slave side is the surrounding pipeline.
interface fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic [31:0]      imemload;
    logic             imemREN;
    logic [31:0]      imemaddr;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             halt_in;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc;
    logic [31:0]      if_npc;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        input  ihit, imemload, stall,
        input  redirect, redirect_pc, halt_in,
        output imemREN, imemaddr,
        output if_valid, if_instr, if_pc, if_npc,
        output halted, fetch_cnt
    );

    modport slave (
        output ihit, imemload, stall,
        output redirect, redirect_pc, halt_in,
        input  imemREN, imemaddr,
        input  if_valid, if_instr, if_pc, if_npc,
        input  halted, fetch_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the icache request and fills the
// IF/ID latch; redirect squashes, stall freezes, halt stops fetch until reset.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          CNT_W   = 32
) (
    input logic         CLK,
    input logic         nRST,
    fetch_stage_if.master bus
);
    typedef enum logic {FETCH, HALTED} state_t;

    state_t           state, state_n;
    logic [31:0]      pc, pc_n;
    logic             valid, valid_n;
    logic [31:0]      instr, instr_n;
    logic [31:0]      ipc, ipc_n;
    logic [31:0]      npc, npc_n;
    logic             halted_q, halted_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ren;

    assign ren = nRST && (state == FETCH) && !bus.redirect
              && (!valid || !bus.stall);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= FETCH;
            pc       <= PC_INIT;
            valid    <= 1'b0;
            instr    <= '0;
            ipc      <= '0;
            npc      <= '0;
            halted_q <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            valid    <= valid_n;
            instr    <= instr_n;
            ipc      <= ipc_n;
            npc      <= npc_n;
            halted_q <= halted_n;
            cnt      <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        valid_n  = valid;
        instr_n  = instr;
        ipc_n    = ipc;
        npc_n    = npc;
        halted_n = halted_q;
        cnt_n    = cnt;
        if (state == FETCH) begin
            // The resolved branch is older than any halt or hit this cycle.
            if (bus.redirect) begin
                pc_n    = bus.redirect_pc & 32'hFFFF_FFFC;
                valid_n = 1'b0;
            end else if (bus.halt_in) begin
                state_n  = HALTED;
                valid_n  = 1'b0;
                halted_n = 1'b1;
            end else if (ren && bus.ihit) begin
                instr_n = bus.imemload;
                ipc_n   = pc;
                npc_n   = pc + 32'd4;
                valid_n = 1'b1;
                pc_n    = pc + 32'd4;
                cnt_n   = cnt + CNT_W'(1);
            end else if (valid && !bus.stall) begin
                valid_n = 1'b0;
            end
        end
    end

    assign bus.imemREN   = ren;
    assign bus.imemaddr  = pc;
    assign bus.if_valid  = valid;
    assign bus.if_instr  = instr;
    assign bus.if_pc     = ipc;
    assign bus.if_npc    = npc;
    assign bus.halted    = halted_q;
    assign bus.fetch_cnt = cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected IF/ID entries,
// a negedge monitor pops one whenever decode consumes the latch.
module tb_fetch_stage;
    logic CLK = 1'b0;
    logic nRST = 1'b0;

    always #5 CLK = ~CLK;

    fetch_stage_if #(.CNT_W(32)) a ();
    fetch_stage_if #(.CNT_W(32)) b ();

    fetch_stage #(.PC_INIT(32'h0000_0000), .CNT_W(32)) u0 (
        .CLK (CLK),
        .nRST(nRST),
        .bus (a.master)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC), .CNT_W(32)) u1 (
        .CLK (CLK),
        .nRST(nRST),
        .bus (b.master)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] w);
        exp_t e;
        e.pc    = pc;
        e.instr = w;
        e.npc   = pc + 32'd4;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (nRST && a.if_valid && !a.stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected no entry",
                         a.if_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", a.if_pc, e.pc);
                chk("sb_instr", a.if_instr, e.instr);
                chk("sb_npc", a.if_npc, e.npc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        a.ihit = 0; a.imemload = 0; a.stall = 0;
        a.redirect = 0; a.redirect_pc = 0; a.halt_in = 0;
        b.ihit = 0; b.imemload = 0; b.stall = 0;
        b.redirect = 0; b.redirect_pc = 0; b.halt_in = 0;

        // T1 reset
        cyc();
        chk("rst_ren", 32'(a.imemREN), 32'd0);
        cyc();
        chk("rst_valid", 32'(a.if_valid), 32'd0);
        chk("rst_cnt", a.fetch_cnt, 32'd0);
        nRST = 1;
        #1;
        chk("t1_addr", a.imemaddr, 32'h0);
        chk("t1_ren", 32'(a.imemREN), 32'd1);
        chk("t1_halted", 32'(a.halted), 32'd0);

        // T2 streaming
        a.ihit = 1;
        a.imemload = 32'hAAAA_0001; push(32'h0, 32'hAAAA_0001); cyc();
        a.imemload = 32'hBBBB_0002; push(32'h4, 32'hBBBB_0002); cyc();
        a.imemload = 32'hCCCC_0003; push(32'h8, 32'hCCCC_0003); cyc();
        a.imemload = 32'hDDDD_0004; push(32'hC, 32'hDDDD_0004); cyc();
        a.ihit = 0;
        chk("t2_pc", a.if_pc, 32'hC);
        chk("t2_cnt", a.fetch_cnt, 32'd4);
        chk("t2_addr", a.imemaddr, 32'h10);
        cyc();
        chk("t2_bubble", 32'(a.if_valid), 32'd0);

        // T3 stall
        a.ihit = 1;
        a.imemload = 32'hEEEE_0005; push(32'h10, 32'hEEEE_0005);
        cyc();
        a.stall = 1;
        a.imemload = 32'hFFFF_0006;
        #1;
        chk("t3_ren", 32'(a.imemREN), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_valid", 32'(a.if_valid), 32'd1);
            chk("t3_pc", a.if_pc, 32'h10);
            chk("t3_instr", a.if_instr, 32'hEEEE_0005);
            chk("t3_addr", a.imemaddr, 32'h14);
        end
        a.stall = 0;
        push(32'h14, 32'hFFFF_0006);
        #1;
        chk("t3_ren_rel", 32'(a.imemREN), 32'd1);
        cyc();
        chk("t3_next", a.if_pc, 32'h14);

        // T4 redirect drops same-cycle hit
        a.redirect = 1;
        a.redirect_pc = 32'h0000_0103;
        a.imemload = 32'h1234_5678;
        #1;
        chk("t4_ren", 32'(a.imemREN), 32'd0);
        cyc();
        chk("t4_valid", 32'(a.if_valid), 32'd0);
        chk("t4_addr", a.imemaddr, 32'h100);
        chk("t4_cnt", a.fetch_cnt, 32'd6);

        // T5 redirect beats halt, then halt alone
        a.ihit = 0;
        a.redirect_pc = 32'h0000_0200;
        a.halt_in = 1;
        cyc();
        chk("t5_halted0", 32'(a.halted), 32'd0);
        chk("t5_addr", a.imemaddr, 32'h200);
        a.redirect = 0;
        a.ihit = 1;
        a.imemload = 32'hDEAD_BEEF;
        cyc();
        a.halt_in = 0;
        a.redirect = 1;
        a.redirect_pc = 32'h0000_0300;
        #1;
        chk("t5_halted1", 32'(a.halted), 32'd1);
        chk("t5_ren", 32'(a.imemREN), 32'd0);
        cyc();
        cyc();
        chk("t5_frozen", a.imemaddr, 32'h200);
        chk("t5_cnt", a.fetch_cnt, 32'd6);
        chk("t5_valid", 32'(a.if_valid), 32'd0);
        a.redirect = 0;
        a.ihit = 0;

        // reset leaves HALTED
        nRST = 0;
        cyc();
        nRST = 1;
        #1;
        chk("rst2_halted", 32'(a.halted), 32'd0);
        chk("rst2_addr", a.imemaddr, 32'h0);
        chk("rst2_ren", 32'(a.imemREN), 32'd1);

        // T6 wrap and miss on the second instance
        chk("t6_init", b.imemaddr, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_miss_addr", b.imemaddr, 32'hFFFF_FFFC);
            chk("t6_miss_valid", 32'(b.if_valid), 32'd0);
            chk("t6_miss_ren", 32'(b.imemREN), 32'd1);
        end
        b.ihit = 1;
        b.imemload = 32'h5A5A_A5A5;
        cyc();
        b.ihit = 0;
        chk("t6_valid", 32'(b.if_valid), 32'd1);
        chk("t6_pc", b.if_pc, 32'hFFFF_FFFC);
        chk("t6_npc", b.if_npc, 32'h0);
        chk("t6_instr", b.if_instr, 32'h5A5A_A5A5);
        chk("t6_addr", b.imemaddr, 32'h0);
        chk("t6_cnt", b.fetch_cnt, 32'd1);

        cyc();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
